// File: rtl/divide_by_21.sv
// Sequential unsigned divide-by-21: one restoring step per cycle, MSB first.
// Optional result self-check enabled by defining DIVIDE_BY_21_SELFCHECK_EN.
module divide_by_21 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_a,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_q,
    output logic [4:0]   out_r,
    input  logic         out_rdy,
    output logic         fail
);

    localparam int         CW      = $clog2(W);
    localparam logic [5:0] DIVISOR = 6'd21;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, q_reg, q_next;
    logic [5:0]      rem_reg, rem_shift, rem_next;
    logic [CW-1:0]   cnt_reg;
    logic            a_bit, q_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_vld)          state_next = BUSY;
            BUSY:    if (cnt_reg == '0)   state_next = DONE;
            DONE:    if (out_rdy)         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    assign in_rdy  = (state_reg == IDLE);
    assign out_vld = (state_reg == DONE);

    // The remainder stays below 21 after each step, so the shifted value fits 6 bits.
    always_comb begin
        a_bit     = a_reg[cnt_reg];
        rem_shift = (rem_reg << 1) | {5'd0, a_bit};
        q_bit     = (rem_shift >= DIVISOR);
        rem_next  = q_bit ? (rem_shift - DIVISOR) : rem_shift;
    end

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_qbit
            assign q_next[gi] = (cnt_reg == CW'(gi)) ? q_bit : q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            q_reg   <= '0;
            rem_reg <= '0;
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_vld) begin
                        a_reg   <= in_a;
                        q_reg   <= '0;
                        rem_reg <= '0;
                        cnt_reg <= CW'(W - 1);
                    end
                end
                BUSY: begin
                    q_reg   <= q_next;
                    rem_reg <= rem_next;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_q = q_reg;
    assign out_r = rem_reg[4:0];

`ifdef DIVIDE_BY_21_SELFCHECK_EN
    localparam int XW = W + 5;

    logic [XW-1:0] q_ext, recon, a_ext;
    logic          mismatch, fail_reg;

    // q*21 + r rebuilt by shift-add on widened operands, judged on the final step.
    always_comb begin
        q_ext    = XW'(q_next);
        a_ext    = XW'(a_reg);
        recon    = (q_ext << 4) + (q_ext << 2) + q_ext + XW'(rem_next);
        mismatch = (recon != a_ext) || (rem_next > 6'd20);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_reg <= 1'b0;
        end else if (state_reg == IDLE && in_vld) begin
            fail_reg <= 1'b0;
        end else if (state_reg == BUSY && cnt_reg == '0) begin
            fail_reg <= mismatch;
        end
    end

    assign fail = fail_reg;
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_divide_by_21.sv
// Directed and randomised checks of divide_by_21 (W=32): latency, hold, reset, throughput.
module tb_divide_by_21;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld;
    logic [W-1:0] in_a;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_q;
    logic [4:0]   out_r;
    logic         out_rdy;
    logic         fail;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    divide_by_21 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_a    (in_a),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_q   (out_q),
        .out_r   (out_r),
        .out_rdy (out_rdy),
        .fail    (fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a);
        int n = 0;
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("in_rdy wait", 64'(in_rdy), 64'd1);
        in_vld = 1'b1;
        in_a   = a;
        @(negedge clk);
        in_vld = 1'b0;
        in_a   = ~a;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!out_vld && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic consume(input string tag);
        out_rdy = 1'b1;
        @(negedge clk);
        check({tag, " out_vld after consume"}, 64'(out_vld), 64'd0);
        check({tag, " in_rdy after consume"}, 64'(in_rdy), 64'd1);
        out_rdy = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] eq, input logic [4:0] er,
                          input string tag);
        int k;
        start_op(a);
        wait_done(k);
        check({tag, " latency"}, 64'(k), 64'(W));
        check({tag, " q"}, 64'(out_q), 64'(eq));
        check({tag, " r"}, 64'(out_r), 64'(er));
        check({tag, " fail"}, 64'(fail), 64'd0);
        check({tag, " in_rdy in DONE"}, 64'(in_rdy), 64'd0);
        $display("%s: a=%0d q=%0d r=%0d latency=%0d", tag, a, out_q, out_r, k);
        consume(tag);
    endtask

    initial begin
        int            k;
        int            t_prev;
        logic [W-1:0]  held_q;
        logic [4:0]    held_r;
        logic [W-1:0]  ra;
        logic [W-1:0]  tp_a [3];

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_a    = '0;
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_rdy", 64'(in_rdy), 64'd1);
        check("reset out_vld", 64'(out_vld), 64'd0);
        check("reset q", 64'(out_q), 64'd0);
        check("reset r", 64'(out_r), 64'd0);
        check("reset fail", 64'(fail), 64'd0);
        rst_n = 1'b1;

        run_op(32'd0,          32'd0,         5'd0,  "zero");
        run_op(32'd21,         32'd1,         5'd0,  "a21");
        run_op(32'd20,         32'd0,         5'd20, "a20");
        run_op(32'hFFFF_FFFF,  32'd204522252, 5'd3,  "allones");
        run_op(32'h8000_0000,  32'd102261126, 5'd2,  "msb");

        // Stall in DONE with new dividends offered: result must hold.
        start_op(32'd100);
        wait_done(k);
        check("hold latency", 64'(k), 64'(W));
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1;
            in_a   = 32'(i * 7919 + 5);
            @(negedge clk);
            check("hold q", 64'(out_q), 64'd4);
            check("hold r", 64'(out_r), 64'd16);
            check("hold out_vld", 64'(out_vld), 64'd1);
            check("hold in_rdy", 64'(in_rdy), 64'd0);
        end
        $display("hold: a=100 q=%0d r=%0d after 5 stalled cycles", out_q, out_r);
        out_rdy = 1'b1;
        @(negedge clk);
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        check("hold consumed out_vld", 64'(out_vld), 64'd0);
        check("hold consumed in_rdy", 64'(in_rdy), 64'd1);

        // Reset mid-BUSY, then accept on the first edge after release.
        start_op(32'd123456);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_vld", 64'(out_vld), 64'd0);
        check("midreset in_rdy", 64'(in_rdy), 64'd1);
        check("midreset q", 64'(out_q), 64'd0);
        check("midreset r", 64'(out_r), 64'd0);
        check("midreset fail", 64'(fail), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd1000, 32'd47, 5'd13, "after_reset");

        // Back-to-back with out_rdy held high: one result every W+2 cycles.
        tp_a[0] = 32'd42;
        tp_a[1] = 32'd43;
        tp_a[2] = 32'd440;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_a    = tp_a[0];
        t_prev  = 0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            @(negedge clk);
            while (!out_vld && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("tp q", 64'(out_q), 64'(tp_a[i] / 21));
            check("tp r", 64'(out_r), 64'(tp_a[i] % 21));
            if (i > 0) check("tp interval", 64'(cyc - t_prev), 64'(W + 2));
            $display("tp%0d: a=%0d q=%0d r=%0d at cycle %0d", i, tp_a[i], out_q, out_r, cyc);
            t_prev = cyc;
            if (i < 2) in_a = tp_a[i + 1];
            else in_vld = 1'b0;
        end
        @(negedge clk);
        out_rdy = 1'b0;

        // Random dividends against a / 21 reference, random consumer stalls.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            if (i % 50 == 0) ra = 32'(i);
            start_op(ra);
            wait_done(k);
            check("rnd latency", 64'(k), 64'(W));
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                @(negedge clk);
            end
            check("rnd q", 64'(out_q), 64'(ra / 21));
            check("rnd r", 64'(out_r), 64'(ra % 21));
            check("rnd fail", 64'(fail), 64'd0);
            $display("rnd%0d: a=%0d q=%0d r=%0d", i, ra, out_q, out_r);
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
